// File: rtl/common_pkg.sv
// Shared core-wide types: architectural register addresses and 64-bit words.
package common;

    typedef logic [4:0]  creg_addr_t;
    typedef logic [63:0] u64;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-control types: fetch FSM states, reset PC and scoreboard counter width.
package pipes;

    import common::*;

    localparam u64 PC_RESET_DEFAULT = 64'h8000_0000;
    localparam int SB_CNT_W_DEFAULT = 2;

    typedef logic [SB_CNT_W_DEFAULT-1:0] sb_cnt_t;

    typedef enum logic [1:0] {
        F_REQ,
        F_DROP,
        F_FULL
    } fetch_state_t;

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// Register scoreboard: one saturating in-flight write counter per register x1..x31.
// x0 is never tracked and never reports busy. Overflow/underflow sets a sticky error.
module pipe_ctrl_scoreboard
    import common::*;
#(
    parameter int CNT_W = pipes::SB_CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       set_en,
    input  creg_addr_t set_idx,
    input  logic       clr_en,
    input  creg_addr_t clr_idx,
    input  creg_addr_t query_a,
    input  creg_addr_t query_b,
    output logic       busy_a,
    output logic       busy_b,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             err_q;
    logic             err_d;

    // Next counter values: +1 on issue, -1 on retire, net zero when both hit the same register.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int r = 1; r < 32; r++) begin
            if ((set_en && set_idx == 5'(r)) && !(clr_en && clr_idx == 5'(r))) begin
                if (cnt_q[r] == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end
            end else if ((clr_en && clr_idx == 5'(r)) && !(set_en && set_idx == 5'(r))) begin
                if (cnt_q[r] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // Counter and sticky-error registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign busy_a = (query_a != '0) && (cnt_q[query_a] != '0);
    assign busy_b = (query_b != '0) && (cnt_q[query_b] != '0);
    assign err    = err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns the PC and fetch FSM (with a one-entry skid buffer),
// interlocks decode on RAW hazards via the scoreboard, and handles E-stage redirects.
module pipe_ctrl
    import common::*;
    import pipes::*;
#(
    parameter u64 PC_RESET = PC_RESET_DEFAULT,
    parameter int SB_CNT_W = SB_CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output logic        fd_load,
    output logic [31:0] fd_instr,
    output logic [63:0] fd_pc,
    input  logic        d_valid,
    input  creg_addr_t  d_ra1,
    input  creg_addr_t  d_ra2,
    input  logic        d_use1,
    input  logic        d_use2,
    input  logic        d_wen,
    input  creg_addr_t  d_dst,
    output logic        issue,
    output logic        bubble_e,
    output logic        flush_d,
    input  logic        ex_redirect,
    input  logic [63:0] ex_target,
    input  logic        wb_valid,
    input  logic        wb_wen,
    input  creg_addr_t  wb_dst,
    input  logic        freeze,
    output logic        sb_err
);

    fetch_state_t state_q, state_d;
    u64           pc_q, pc_d;
    u64           ireq_addr_q, ireq_addr_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    u64           buf_pc_q, buf_pc_d;

    logic busy1, busy2;
    logic hazard;
    logic d_accept;
    logic fd_load_raw;

    pipe_ctrl_scoreboard #(
        .CNT_W (SB_CNT_W)
    ) u_scoreboard (
        .clk     (clk),
        .resetn  (resetn),
        .set_en  (issue & d_wen),
        .set_idx (d_dst),
        .clr_en  (wb_valid & wb_wen),
        .clr_idx (wb_dst),
        .query_a (d_ra1),
        .query_b (d_ra2),
        .busy_a  (busy1),
        .busy_b  (busy2),
        .err     (sb_err)
    );

    // Issue/stall/flush decisions; everything is held low while reset is asserted.
    always_comb begin
        hazard   = d_valid & ((d_use1 & busy1) | (d_use2 & busy2));
        issue    = resetn & d_valid & ~hazard & ~freeze & ~ex_redirect;
        bubble_e = resetn & ~issue & ~freeze;
        flush_d  = resetn & ex_redirect;
        d_accept = (~d_valid | issue) & ~ex_redirect;
    end

    // Fetch FSM next state: PC/request address updates, skid buffer fill and drain.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ireq_addr_d = ireq_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        fd_load_raw = 1'b0;
        fd_instr    = iresp_data;
        fd_pc       = ireq_addr_q;
        unique case (state_q)
            F_REQ: begin
                if (ex_redirect) begin
                    pc_d = ex_target;
                    if (iresp_ok) begin
                        ireq_addr_d = ex_target;
                    end else begin
                        state_d = F_DROP;
                    end
                end else if (iresp_ok) begin
                    pc_d = pc_q + 64'd4;
                    if (d_accept) begin
                        fd_load_raw = 1'b1;
                        ireq_addr_d = pc_q + 64'd4;
                    end else begin
                        buf_instr_d = iresp_data;
                        buf_pc_d    = ireq_addr_q;
                        state_d     = F_FULL;
                    end
                end
            end
            F_DROP: begin
                if (ex_redirect) begin
                    pc_d = ex_target;
                end
                if (iresp_ok) begin
                    ireq_addr_d = ex_redirect ? ex_target : pc_q;
                    state_d     = F_REQ;
                end
            end
            F_FULL: begin
                fd_instr = buf_instr_q;
                fd_pc    = buf_pc_q;
                if (ex_redirect) begin
                    pc_d        = ex_target;
                    ireq_addr_d = ex_target;
                    state_d     = F_REQ;
                end else if (d_accept) begin
                    fd_load_raw = 1'b1;
                    ireq_addr_d = pc_q;
                    state_d     = F_REQ;
                end
            end
            default: begin
                state_d = F_REQ;
            end
        endcase
    end

    // Fetch FSM, PC and skid-buffer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= F_REQ;
            pc_q        <= PC_RESET;
            ireq_addr_q <= PC_RESET;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ireq_addr_q <= ireq_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign ireq_valid = resetn & (state_q != F_FULL);
    assign ireq_addr  = ireq_addr_q;
    assign fd_load    = resetn & fd_load_raw;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch path and an integer-count scoreboard.
module tb_pipe_ctrl;

    import common::*;

    localparam logic [63:0] PC0 = 64'h8000_0000;

    logic        clk;
    logic        resetn;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        fd_load;
    logic [31:0] fd_instr;
    logic [63:0] fd_pc;
    logic        d_valid;
    logic [4:0]  d_ra1, d_ra2;
    logic        d_use1, d_use2;
    logic        d_wen;
    logic [4:0]  d_dst;
    logic        issue;
    logic        bubble_e;
    logic        flush_d;
    logic        ex_redirect;
    logic [63:0] ex_target;
    logic        wb_valid, wb_wen;
    logic [4:0]  wb_dst;
    logic        freeze;
    logic        sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl #(
        .PC_RESET (64'h8000_0000),
        .SB_CNT_W (2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .iresp_ok    (iresp_ok),
        .iresp_data  (iresp_data),
        .fd_load     (fd_load),
        .fd_instr    (fd_instr),
        .fd_pc       (fd_pc),
        .d_valid     (d_valid),
        .d_ra1       (d_ra1),
        .d_ra2       (d_ra2),
        .d_use1      (d_use1),
        .d_use2      (d_use2),
        .d_wen       (d_wen),
        .d_dst       (d_dst),
        .issue       (issue),
        .bubble_e    (bubble_e),
        .flush_d     (flush_d),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .wb_valid    (wb_valid),
        .wb_wen      (wb_wen),
        .wb_dst      (wb_dst),
        .freeze      (freeze),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle_inputs();
        iresp_ok    = 1'b0;
        iresp_data  = '0;
        d_valid     = 1'b0;
        d_ra1       = '0;
        d_ra2       = '0;
        d_use1      = 1'b0;
        d_use2      = 1'b0;
        d_wen       = 1'b0;
        d_dst       = '0;
        ex_redirect = 1'b0;
        ex_target   = '0;
        wb_valid    = 1'b0;
        wb_wen      = 1'b0;
        wb_dst      = '0;
        freeze      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        d_valid = 1'b1;
        ex_redirect = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ireq_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ireq_valid: got %0b want 0", ireq_valid); end
        n_tests++;
        if (ireq_addr !== PC0) begin n_fail++; $display("[TB] FAIL reset_ireq_addr: got %h want %h", ireq_addr, PC0); end
        n_tests++;
        if ({issue, fd_load, flush_d, bubble_e} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL reset_outputs: got %b want 0000", {issue, fd_load, flush_d, bubble_e});
        end
        n_tests++;
        if (sb_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sb_err: got %0b want 0", sb_err); end
        @(posedge clk);
        #1;
        idle_inputs();
        resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ireq_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL release_ireq_valid: got %0b want 1", ireq_valid); end
        n_tests++;
        if (ireq_addr !== PC0) begin n_fail++; $display("[TB] FAIL release_ireq_addr: got %h want %h", ireq_addr, PC0); end
    endtask

    task automatic test_first_fetch();
        apply_reset();
        iresp_ok   = 1'b1;
        iresp_data = 32'h0000_0013;
        @(negedge clk);
        n_tests++;
        if (fd_load !== 1'b1 || fd_instr !== 32'h13 || fd_pc !== PC0) begin
            n_fail++; $display("[TB] FAIL first_fetch: got load=%0b instr=%h pc=%h want 1 00000013 %h", fd_load, fd_instr, fd_pc, PC0);
        end
        tick();
        iresp_ok = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ireq_valid !== 1'b1 || ireq_addr !== PC0 + 64'd4) begin
            n_fail++; $display("[TB] FAIL first_fetch_next_addr: got v=%0b addr=%h want 1 %h", ireq_valid, ireq_addr, PC0 + 64'd4);
        end
    endtask

    task automatic test_raw_interlock();
        apply_reset();
        d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd5;
        @(negedge clk);
        n_tests++;
        if (issue !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_first_issue: got %0b want 1", issue); end
        tick();
        d_wen = 1'b0; d_use1 = 1'b1; d_ra1 = 5'd5;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin wb_valid = 1'b1; wb_wen = 1'b1; wb_dst = 5'd5; end
            @(negedge clk);
            n_tests++;
            if (issue !== 1'b0 || bubble_e !== 1'b1) begin
                n_fail++; $display("[TB] FAIL raw_stall_%0d: got issue=%0b bubble=%0b want 0 1", i, issue, bubble_e);
            end
            tick();
        end
        wb_valid = 1'b0;
        d_wen = 1'b1; d_dst = 5'd0;
        @(negedge clk);
        n_tests++;
        if (issue !== 1'b1 || bubble_e !== 1'b0) begin
            n_fail++; $display("[TB] FAIL raw_after_wb: got issue=%0b bubble=%0b want 1 0", issue, bubble_e);
        end
        tick();
        d_wen = 1'b0; d_ra1 = 5'd0; d_use2 = 1'b1; d_ra2 = 5'd0;
        @(negedge clk);
        n_tests++;
        if (issue !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_x0_never_stalls: got %0b want 1", issue); end
    endtask

    task automatic test_redirect_drop();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            iresp_ok = 1'b1; iresp_data = 32'h100 + 32'(i);
            tick();
        end
        iresp_ok = 1'b0; ex_redirect = 1'b1; ex_target = 64'h8000_0100;
        @(negedge clk);
        n_tests++;
        if (flush_d !== 1'b1 || fd_load !== 1'b0 || issue !== 1'b0 || ireq_addr !== 64'h8000_0010) begin
            n_fail++; $display("[TB] FAIL redirect_cycle: got flush=%0b load=%0b issue=%0b addr=%h want 1 0 0 80000010", flush_d, fd_load, issue, ireq_addr);
        end
        tick();
        ex_redirect = 1'b0; iresp_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010 || fd_load !== 1'b0) begin
            n_fail++; $display("[TB] FAIL drop_late_resp: got v=%0b addr=%h load=%0b want 1 80000010 0", ireq_valid, ireq_addr, fd_load);
        end
        tick();
        iresp_ok = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100) begin
            n_fail++; $display("[TB] FAIL redirect_new_addr: got v=%0b addr=%h want 1 80000100", ireq_valid, ireq_addr);
        end
    endtask

    task automatic test_skid_buffer();
        apply_reset();
        d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd3;
        tick();
        d_wen = 1'b0; d_use1 = 1'b1; d_ra1 = 5'd3;
        iresp_ok = 1'b1; iresp_data = 32'hABCD_0123;
        @(negedge clk);
        n_tests++;
        if (fd_load !== 1'b0 || issue !== 1'b0) begin
            n_fail++; $display("[TB] FAIL skid_capture: got load=%0b issue=%0b want 0 0", fd_load, issue);
        end
        tick();
        iresp_ok = 1'b0; wb_valid = 1'b1; wb_wen = 1'b1; wb_dst = 5'd3;
        @(negedge clk);
        n_tests++;
        if (ireq_valid !== 1'b0 || fd_load !== 1'b0) begin
            n_fail++; $display("[TB] FAIL skid_full_hold: got v=%0b load=%0b want 0 0", ireq_valid, fd_load);
        end
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (issue !== 1'b1 || fd_load !== 1'b1 || fd_instr !== 32'hABCD_0123 || fd_pc !== PC0) begin
            n_fail++; $display("[TB] FAIL skid_drain: got issue=%0b load=%0b instr=%h pc=%h want 1 1 abcd0123 %h", issue, fd_load, fd_instr, fd_pc, PC0);
        end
        tick();
        d_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ireq_valid !== 1'b1 || ireq_addr !== PC0 + 64'd4) begin
            n_fail++; $display("[TB] FAIL skid_back_to_req: got v=%0b addr=%h want 1 %h", ireq_valid, ireq_addr, PC0 + 64'd4);
        end
    endtask

    task automatic test_freeze();
        apply_reset();
        d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd9; freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (issue !== 1'b0 || bubble_e !== 1'b0) begin
                n_fail++; $display("[TB] FAIL freeze_%0d: got issue=%0b bubble=%0b want 0 0", i, issue, bubble_e);
            end
            tick();
        end
        freeze = 1'b0; d_wen = 1'b0; d_use1 = 1'b1; d_ra1 = 5'd9;
        @(negedge clk);
        n_tests++;
        if (issue !== 1'b1 || bubble_e !== 1'b0) begin
            n_fail++; $display("[TB] FAIL freeze_release: got issue=%0b bubble=%0b want 1 0", issue, bubble_e);
        end
    endtask

    task automatic test_same_reg();
        apply_reset();
        d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd7;
        tick();
        wb_valid = 1'b1; wb_wen = 1'b1; wb_dst = 5'd7;
        tick();
        d_wen = 1'b0; d_use1 = 1'b1; d_ra1 = 5'd7;
        @(negedge clk);
        n_tests++;
        if (issue !== 1'b0) begin n_fail++; $display("[TB] FAIL same_reg_net_zero: got issue=%0b want 0", issue); end
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (issue !== 1'b1 || sb_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL same_reg_retired: got issue=%0b err=%0b want 1 0", issue, sb_err);
        end
        tick();
        d_valid = 1'b0; wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (sb_err !== 1'b1) begin n_fail++; $display("[TB] FAIL underflow_err: got %0b want 1", sb_err); end
        tick();
        @(negedge clk);
        n_tests++;
        if (sb_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %0b want 1", sb_err); end
    endtask

    task automatic test_random();
        logic [63:0] m_pc;
        logic [63:0] m_addr;
        bit          m_drop;
        logic [31:0] bq_instr [$];
        logic [63:0] bq_pc [$];
        int          m_cnt [32];
        bit          m_err;
        bit          e_ivalid, e_haz, e_issue, e_bubble, e_acc, e_load;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        bit          inc, dec;

        apply_reset();
        m_pc = PC0; m_addr = PC0; m_drop = 0; m_err = 0;
        bq_instr.delete(); bq_pc.delete();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            e_ivalid    = (bq_instr.size() == 0);
            d_valid     = ($urandom_range(0, 3) != 0);
            d_ra1       = 5'($urandom_range(0, 7));
            d_ra2       = 5'($urandom_range(0, 7));
            d_use1      = 1'($urandom_range(0, 1));
            d_use2      = 1'($urandom_range(0, 1));
            d_wen       = 1'($urandom_range(0, 1));
            d_dst       = 5'($urandom_range(0, 7));
            freeze      = ($urandom_range(0, 5) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            ex_target   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
            iresp_ok    = e_ivalid && ($urandom_range(0, 1) == 1);
            iresp_data  = $urandom;
            wb_dst      = 5'($urandom_range(0, 7));
            wb_wen      = ($urandom_range(0, 3) != 0);
            wb_valid    = (m_cnt[wb_dst] > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 127) == 0);

            e_haz    = d_valid && ((d_use1 && d_ra1 != 0 && m_cnt[d_ra1] != 0) ||
                                   (d_use2 && d_ra2 != 0 && m_cnt[d_ra2] != 0));
            e_issue  = d_valid && !e_haz && !freeze && !ex_redirect;
            e_bubble = !e_issue && !freeze;
            e_acc    = (!d_valid || e_issue) && !ex_redirect;
            if (bq_instr.size() > 0) begin
                e_load = e_acc; e_instr = bq_instr[0]; e_pc = bq_pc[0];
            end else begin
                e_load = !m_drop && iresp_ok && e_acc; e_instr = iresp_data; e_pc = m_addr;
            end

            @(negedge clk);
            n_tests++;
            if (ireq_valid !== e_ivalid || (e_ivalid && ireq_addr !== m_addr)) begin
                n_fail++; $display("[TB] FAIL rnd_ireq cyc=%0d: got v=%0b addr=%h want v=%0b addr=%h", cyc, ireq_valid, ireq_addr, e_ivalid, m_addr);
            end
            n_tests++;
            if (issue !== e_issue || bubble_e !== e_bubble || flush_d !== ex_redirect) begin
                n_fail++; $display("[TB] FAIL rnd_ctrl cyc=%0d: got issue=%0b bubble=%0b flush=%0b want %0b %0b %0b", cyc, issue, bubble_e, flush_d, e_issue, e_bubble, ex_redirect);
            end
            n_tests++;
            if (fd_load !== e_load || (e_load && (fd_instr !== e_instr || fd_pc !== e_pc))) begin
                n_fail++; $display("[TB] FAIL rnd_fd cyc=%0d: got load=%0b instr=%h pc=%h want %0b %h %h", cyc, fd_load, fd_instr, fd_pc, e_load, e_instr, e_pc);
            end
            n_tests++;
            if (sb_err !== m_err) begin
                n_fail++; $display("[TB] FAIL rnd_sb_err cyc=%0d: got %0b want %0b", cyc, sb_err, m_err);
            end

            @(posedge clk);
            inc = e_issue && d_wen && d_dst != 0;
            dec = wb_valid && wb_wen && wb_dst != 0;
            if (!(inc && dec && d_dst == wb_dst)) begin
                if (inc) begin
                    if (m_cnt[d_dst] == 3) m_err = 1; else m_cnt[d_dst]++;
                end
                if (dec) begin
                    if (m_cnt[wb_dst] == 0) m_err = 1; else m_cnt[wb_dst]--;
                end
            end
            if (bq_instr.size() > 0) begin
                if (ex_redirect) begin
                    bq_instr.delete(); bq_pc.delete();
                    m_pc = ex_target; m_addr = ex_target;
                end else if (e_acc) begin
                    void'(bq_instr.pop_front()); void'(bq_pc.pop_front());
                    m_addr = m_pc;
                end
            end else if (m_drop) begin
                if (ex_redirect) m_pc = ex_target;
                if (iresp_ok) begin m_addr = m_pc; m_drop = 0; end
            end else if (ex_redirect) begin
                m_pc = ex_target;
                if (iresp_ok) m_addr = ex_target; else m_drop = 1;
            end else if (iresp_ok) begin
                if (!e_acc) begin bq_instr.push_back(iresp_data); bq_pc.push_back(m_addr); end
                m_pc = m_pc + 64'd4;
                if (e_acc) m_addr = m_pc;
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_raw_interlock();
        test_redirect_drop();
        test_skid_buffer();
        test_freeze();
        test_same_reg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
